// File: rtl/int_to_bcd_pkg.sv
// Shared definitions for the integer-to-BCD conversion path.
//   INT_WIDTH  : width of the two's-complement integer from the FP->int stage
//   BCD_DIGITS : decimal digits needed to hold 2^(INT_WIDTH-1)
//   state_t    : converter FSM states
package int_to_bcd_pkg;

    localparam int INT_WIDTH  = 64;
    localparam int BCD_DIGITS = 19;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/int_to_bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more,
// so that the following left shift carries correctly into the next digit.
// The result is truncated to 4 bits; there is no carry out.
//   din  : BCD digit before correction
//   dout : corrected digit
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din >= 4'd5)
            dout = din + 4'd3;
    end

endmodule

// File: rtl/int_to_bcd.sv
// Iterative signed-binary to BCD converter, one double-dabble step per clock.
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   in_valid   : int_in is valid
//   in_ready   : converter can accept (IDLE only, also while rst is held)
//   int_in     : two's-complement integer to convert
//   out_valid  : neg/bcd/ndigits valid, held until out_ready
//   out_ready  : consumer accepts the result
//   neg        : input was negative
//   bcd        : magnitude, digit 0 in [3:0], most significant digit on top
//   ndigits    : significant digit count, 1..DIGITS (1 for zero)
module int_to_bcd
    import int_to_bcd_pkg::*;
#(
    parameter int WIDTH  = INT_WIDTH,
    parameter int DIGITS = BCD_DIGITS,
    localparam int CNT_W = $clog2(DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      int_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  neg,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [CNT_W-1:0]      ndigits
);

    localparam int STEP_W = $clog2(WIDTH);

    state_t               state, state_next;
    logic [WIDTH-1:0]     sh;
    logic [WIDTH-1:0]     mag;
    logic [STEP_W-1:0]    cnt;
    logic [4*DIGITS-1:0]  bcd_adj;
    logic                 accept;
    logic                 last_step;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last_step = (cnt == STEP_W'(WIDTH - 1));

    // Negating the most negative value wraps back to itself, which read as
    // unsigned is exactly the required magnitude 2^(WIDTH-1).
    assign mag = int_in[WIDTH-1] ? WIDTH'(-int_in) : int_in;

    for (genvar d = 0; d < DIGITS; d++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (bcd[4*d +: 4]),
            .dout (bcd_adj[4*d +: 4])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept)    state_next = SHIFT;
            SHIFT:   if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh  <= '0;
            bcd <= '0;
            neg <= 1'b0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sh  <= mag;
                        neg <= int_in[WIDTH-1];
                        bcd <= '0;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    {bcd, sh} <= {bcd_adj, sh} << 1;
                    cnt       <= cnt + STEP_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Leading-digit priority encoder: the highest nonzero digit wins.
    always_comb begin
        ndigits = CNT_W'(1);
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd0)
                ndigits = CNT_W'(i + 1);
        end
    end

endmodule

// File: tb/tb_int_to_bcd.sv
module tb_int_to_bcd;

    localparam int W = 64;
    localparam int D = 19;

    typedef struct packed {
        logic          neg;
        logic [4*D-1:0] bcd;
        logic [4:0]    nd;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   int_in = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           neg;
    logic [4*D-1:0] bcd;
    logic [4:0]     ndigits;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    int_to_bcd #(.WIDTH(W), .DIGITS(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .int_in    (int_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .neg       (neg),
        .bcd       (bcd),
        .ndigits   (ndigits)
    );

    function automatic exp_t model(input logic [W-1:0] v);
        exp_t e;
        logic [W-1:0] m;
        e.neg = v[W-1];
        m = v[W-1] ? (~v + 64'd1) : v;
        e.bcd = '0;
        e.nd  = 5'd1;
        for (int i = 0; i < D; i++) begin
            e.bcd[4*i +: 4] = 4'(m % 64'd10);
            if (m != 0) e.nd = 5'(i + 1);
            m = m / 64'd10;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Edge count includes the accepting edge itself.
    task automatic convert(input logic [W-1:0] v, input bit pest);
        exp_t e;
        int edges;
        sb.push_back(model(v));
        @(negedge clk);
        chk("in_ready_idle", 80'(in_ready), 80'd1);
        in_valid = 1'b1;
        int_in   = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        int_in   = '0;
        edges    = 1;
        while (out_valid !== 1'b1 && edges < 200) begin
            if (pest && edges == 10) begin
                in_valid = 1'b1;
                int_in   = 64'd777;
            end
            if (pest && edges == 15) begin
                chk("in_ready_shift", 80'(in_ready), 80'd0);
                in_valid = 1'b0;
                int_in   = '0;
            end
            @(posedge clk); #1;
            edges++;
        end
        chk("latency", 80'(edges), 80'd65);
        if (pest) begin
            repeat (10) @(posedge clk);
            #1;
            chk("held_valid", 80'(out_valid), 80'd1);
            chk("held_in_ready", 80'(in_ready), 80'd0);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("neg", 80'(neg), 80'(e.neg));
            chk("bcd", 80'(bcd), 80'(e.bcd));
            chk("ndigits", 80'(ndigits), 80'(e.nd));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("valid_drop", 80'(out_valid), 80'd0);
        chk("ready_rise", 80'(in_ready), 80'd1);
    endtask

    initial begin
        #2;
        chk("rst_in_ready", 80'(in_ready), 80'd1);
        chk("rst_out_valid", 80'(out_valid), 80'd0);
        chk("rst_neg", 80'(neg), 80'd0);
        chk("rst_bcd", 80'(bcd), 80'd0);
        chk("rst_ndigits", 80'(ndigits), 80'd1);
        @(negedge clk);
        rst = 1'b0;

        convert(64'd0, 1'b0);
        convert(64'd12345, 1'b0);
        chk("bcd_12345", 80'(bcd), 80'h12345);
        convert(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        chk("neg_m1", 80'(neg), 80'd1);
        convert(64'h8000_0000_0000_0000, 1'b0);
        chk("bcd_min", 80'(bcd), 80'h9223372036854775808);
        chk("nd_min", 80'(ndigits), 80'd19);
        convert(64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        chk("bcd_max", 80'(bcd), 80'h9223372036854775807);
        convert(64'd9999999999, 1'b1);

        // abort a conversion at step 30
        @(negedge clk);
        in_valid = 1'b1;
        int_in   = 64'd55555;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (29) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_valid", 80'(out_valid), 80'd0);
        chk("abort_ready", 80'(in_ready), 80'd1);
        chk("abort_bcd", 80'(bcd), 80'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (70) @(posedge clk);
        #1 chk("abort_no_valid", 80'(out_valid), 80'd0);

        convert(-64'sd987654321, 1'b0);
        chk("bcd_987", 80'(bcd), 80'h987654321);
        chk("nd_987", 80'(ndigits), 80'd9);

        for (int i = 0; i < 4; i++)
            convert({$urandom, $urandom}, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
